// File: rtl/conv_aip_sequencer.sv
// conv_aip_sequencer: autonomous AIP master that loads Y into the convolution coprocessor, starts it and drains Z.
// Latency: cmd_start to first y_ready 3 cycles; interrupt seen to first z_valid 6 cycles; one aip_read per Z word.
// Backpressure: y_ready/z_valid handshakes stall the sequence without losing or repeating words; en_s low freezes everything.
//
// Ports:
//   clk, rst_a (async, active low), en_s (synchronous freeze)
//   cmd_start/cmd_y_len/cmd_z_len : job request, sampled only while idle
//   y_data/y_valid/y_ready        : Y input stream
//   z_data/z_valid/z_ready        : Z output stream
//   busy, done, err               : job status (done/err are 1-cycle pulses)
//   aip_data_in, aip_conf, aip_write, aip_read, aip_start : registered strobes to the coprocessor
//   aip_data_out, aip_int_n       : read data and active-low interrupt from the coprocessor
module conv_aip_sequencer #(
  parameter int DATAWIDTH   = 32,
  parameter int LEN_W       = 7,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic                 cmd_start,
  input  logic [LEN_W-1:0]     cmd_y_len,
  input  logic [LEN_W-1:0]     cmd_z_len,
  input  logic [DATAWIDTH-1:0] y_data,
  input  logic                 y_valid,
  output logic                 y_ready,
  output logic [DATAWIDTH-1:0] z_data,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DATAWIDTH-1:0] aip_data_in,
  output logic [4:0]           aip_conf,
  output logic                 aip_write,
  output logic                 aip_read,
  output logic                 aip_start,
  input  logic [DATAWIDTH-1:0] aip_data_out,
  input  logic                 aip_int_n
);

  localparam logic [4:0] MMEM_Y  = 5'd0;
  localparam logic [4:0] AMEM_Y  = 5'd1;
  localparam logic [4:0] MMEM_Z  = 5'd2;
  localparam logic [4:0] AMEM_Z  = 5'd3;
  localparam logic [4:0] CSIZE_Y = 5'd4;
  localparam logic [4:0] ASIZE_Y = 5'd5;
  localparam logic [4:0] STATUS  = 5'd30;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W-1:0]     MAX_LEN   = LEN_W'(64);
  localparam logic [DATAWIDTH-1:0] ST_INT_EN = DATAWIDTH'(32'h0001_0000);  // mask bit0 = done
  localparam logic [DATAWIDTH-1:0] ST_CLR    = DATAWIDTH'(32'h0001_0001);  // keep mask, clear done flag

  typedef enum logic [3:0] {
    S_IDLE, S_PTR_Y, S_WR_Y, S_PTR_CFG, S_WR_CFG, S_INT_EN, S_START, S_WAIT_INT,
    S_INT_CLR, S_PTR_Z, S_RD_Z, S_RD_WAIT, S_RD_CAP, S_Z_OUT, S_DONE
  } state_t;

  state_t               state_q;
  logic [LEN_W-1:0]     y_len_q, z_len_q, y_cnt_q, z_cnt_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic                 y_ready_q, z_valid_q, busy_q, done_q, err_q;
  logic                 aip_write_q, aip_read_q, aip_start_q;
  logic [4:0]           aip_conf_q;
  logic [DATAWIDTH-1:0] aip_data_q, z_data_q;

  logic cmd_len_ok;
  logic y_beat;
  logic y_last, z_last;

  assign cmd_len_ok = (cmd_y_len != '0) && (cmd_y_len <= MAX_LEN) &&
                      (cmd_z_len != '0) && (cmd_z_len <= MAX_LEN);
  assign y_beat     = y_valid && y_ready_q;
  // Compare against len-1 so a length of 64 never needs a 65th count value.
  assign y_last     = (y_cnt_q == y_len_q - LEN_W'(1));
  assign z_last     = (z_cnt_q == z_len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q     <= S_IDLE;
      y_len_q     <= '0;
      z_len_q     <= '0;
      y_cnt_q     <= '0;
      z_cnt_q     <= '0;
      to_cnt_q    <= '0;
      y_ready_q   <= 1'b0;
      z_valid_q   <= 1'b0;
      z_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      aip_write_q <= 1'b0;
      aip_read_q  <= 1'b0;
      aip_start_q <= 1'b0;
      aip_conf_q  <= '0;
      aip_data_q  <= '0;
    end else if (!en_s) begin
      // Frozen: strobes and pulses drop, all other state holds.
      aip_write_q <= 1'b0;
      aip_read_q  <= 1'b0;
      aip_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      aip_write_q <= 1'b0;
      aip_read_q  <= 1'b0;
      aip_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_len_ok) begin
              y_len_q <= cmd_y_len;
              z_len_q <= cmd_z_len;
              y_cnt_q <= '0;
              z_cnt_q <= '0;
              busy_q  <= 1'b1;
              state_q <= S_PTR_Y;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_PTR_Y: begin
          aip_write_q <= 1'b1;
          aip_conf_q  <= AMEM_Y;
          aip_data_q  <= '0;
          state_q     <= S_WR_Y;
        end
        S_WR_Y: begin
          // First WR_Y cycle only raises y_ready; beats start the cycle after.
          if (!y_ready_q) begin
            y_ready_q <= 1'b1;
          end else if (y_beat) begin
            aip_write_q <= 1'b1;
            aip_conf_q  <= MMEM_Y;
            aip_data_q  <= y_data;
            if (y_last) begin
              y_ready_q <= 1'b0;
              state_q   <= S_PTR_CFG;
            end else begin
              y_cnt_q <= y_cnt_q + LEN_W'(1);
            end
          end
        end
        S_PTR_CFG: begin
          aip_write_q <= 1'b1;
          aip_conf_q  <= ASIZE_Y;
          aip_data_q  <= '0;
          state_q     <= S_WR_CFG;
        end
        S_WR_CFG: begin
          aip_write_q <= 1'b1;
          aip_conf_q  <= CSIZE_Y;
          aip_data_q  <= DATAWIDTH'(y_len_q);
          state_q     <= S_INT_EN;
        end
        S_INT_EN: begin
          aip_write_q <= 1'b1;
          aip_conf_q  <= STATUS;
          aip_data_q  <= ST_INT_EN;
          state_q     <= S_START;
        end
        S_START: begin
          aip_start_q <= 1'b1;
          to_cnt_q    <= '0;
          state_q     <= S_WAIT_INT;
        end
        S_WAIT_INT: begin
          // An interrupt on the final counted cycle still wins over the timeout.
          if (!aip_int_n) begin
            state_q <= S_INT_CLR;
          end else if (to_cnt_q == TO_LAST) begin
            err_q       <= 1'b1;
            aip_write_q <= 1'b1;
            aip_conf_q  <= STATUS;
            aip_data_q  <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_INT_CLR: begin
          aip_write_q <= 1'b1;
          aip_conf_q  <= STATUS;
          aip_data_q  <= ST_CLR;
          state_q     <= S_PTR_Z;
        end
        S_PTR_Z: begin
          aip_write_q <= 1'b1;
          aip_conf_q  <= AMEM_Z;
          aip_data_q  <= '0;
          state_q     <= S_RD_Z;
        end
        S_RD_Z: begin
          aip_read_q <= 1'b1;
          aip_conf_q <= MMEM_Z;
          state_q    <= S_RD_WAIT;
        end
        // Read strobe is on the bus this cycle; data is valid the cycle after.
        S_RD_WAIT: state_q <= S_RD_CAP;
        S_RD_CAP: begin
          z_data_q  <= aip_data_out;
          z_valid_q <= 1'b1;
          state_q   <= S_Z_OUT;
        end
        S_Z_OUT: begin
          if (z_ready) begin
            z_valid_q <= 1'b0;
            if (z_last) begin
              aip_write_q <= 1'b1;
              aip_conf_q  <= STATUS;
              aip_data_q  <= '0;
              state_q     <= S_DONE;
            end else begin
              z_cnt_q <= z_cnt_q + LEN_W'(1);
              state_q <= S_RD_Z;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are qualified by en_s so no transfer is signalled while frozen.
  assign y_ready     = y_ready_q && en_s;
  assign z_valid     = z_valid_q && en_s;
  assign z_data      = z_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign aip_data_in = aip_data_q;
  assign aip_conf    = aip_conf_q;
  assign aip_write   = aip_write_q;
  assign aip_read    = aip_read_q;
  assign aip_start   = aip_start_q;

endmodule
